regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port integer register file with a per-register pending (busy) scoreboard.
//   Supports NRD async read ports and NWR sync write ports; register 0 is optionally hardwired to zero.
//   Sits between decode (reads operands, allocates the destination) and write-back (writes and clears busy).
//   Drop-in generalisation of the single-issue register file for the dual-issue pipeline.
// PARAMETERS
//   XLEN     32  data width in bits
//   NREG     32  number of registers, power of two >= 2; AW = $clog2(NREG) (localparam)
//   NRD       2  number of read ports, >= 1
//   NWR       1  number of write ports, >= 1
//   ZERO_R0   1  1: reg 0 reads as 0, is never written and is never busy
// PORTS
//   clk         in   1        clock, all state updates on rising edge
//   rst         in   1        synchronous reset, active-high
//   rs_addr     in   NRD*AW   read addresses, port i at [i*AW +: AW]
//   rs_data     out  NRD*XLEN read data, port i at [i*XLEN +: XLEN]
//   rs_busy     out  NRD      1 = register at rs_addr[i] has a pending producer
//   wr_en       in   NWR      write enable per write port
//   wr_addr     in   NWR*AW   write addresses
//   wr_data     in   NWR*XLEN write data
//   alloc_en    in   1        decode marks alloc_addr busy (new in-flight producer)
//   alloc_addr  in   AW       register being allocated
// BEHAVIOUR
//   - Reset (rst=1 at posedge): every register <= 0, every busy bit <= 0; this takes priority over all writes/allocs.
//     rs_data=0, rs_busy=0 in the cycle after reset.
//   - Reads are combinational from current state: 0-cycle latency, no read-side handshake.
//   - Write: when wr_en[j] is set, reg[wr_addr[j]] <= wr_data[j] at the next edge and busy[wr_addr[j]] is cleared.
//   - Write collision (same addr on ports j<k in one cycle): the higher port index k wins; busy is cleared once.
//   - Alloc: when alloc_en is set, busy[alloc_addr] <= 1 at the next edge.
//   - Alloc and write to the same addr in one cycle: data is written AND busy ends set (alloc wins).
//     The new producer supersedes the retiring one.
//   - Alloc to an already-busy register: stays busy; there is no count, and the last producer's write clears it.
//   - ZERO_R0=1: writes and allocs to addr 0 are ignored; reads of addr 0 return 0 with busy 0.
//   - ZERO_R0=0: register 0 behaves like any other register.
//   - Address >= NREG is impossible (NREG is a power of two); there is no bounds logic.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - A read whose address matches a same-cycle wr_en write returns wr_data (highest matching port wins)
//       and rs_busy=0, unless alloc_en targets that addr in the same cycle, in which case busy reads 1.
//     - This is a combinational write->read path.
//     - Bypass still never applies to reg 0 when ZERO_R0=1.
//   REGFILE_BYPASS_EN undefined:
//     - Reads return pre-edge state; a same-cycle write becomes visible the next cycle.
// STRUCTURE
//   - Package regfile_pkg holds:
//     - localparam XLEN_DEF=32 and NREG_DEF=32
//     - typedef reg_addr_t (logic [4:0])
//     - typedef xword_t (logic [31:0])
//     - function is_zero_reg(reg_addr_t)
//   - Sub-module regfile_scoreboard (NREG, NWR, ZERO_R0) owns:
//     - the busy bit-vector
//     - the set/clear priority between alloc and write
//     - the per-read busy lookup
//   - Top level instantiates the data array, the write-collision resolution and the optional bypass mux.
// TESTING
//   1. Reset mid-run:
//      - Write reg5=0xDEADBEEF, then alloc reg5, then assert rst for 1 cycle.
//      - Expect: reads of reg5 return 0 with busy 0.
//   2. x0 guard (ZERO_R0=1):
//      - Write 0x1234 to addr 0 and alloc addr 0.
//      - Expect: rs_data=0, rs_busy=0 on every read port.
//   3. Collision (NWR=2):
//      - Same cycle: wr0 reg7=0xAAAA_AAAA, wr1 reg7=0x5555_5555.
//      - Expect: reg7 reads 0x5555_5555 next cycle.
//   4. Scoreboard:
//      - Cycle 0: alloc reg3. Expect rs_busy=1 from cycle 1.
//      - Cycle 4: write reg3=0x42. Expect busy=0 and data 0x42 from cycle 5.
//      - Alloc reg3 together with a write to reg3: expect busy stays 1.
//   5. Bypass, reading reg9 in the same cycle as writing reg9=0xCAFE:
//      - Macro on: rs_data=0xCAFE, busy=0 that cycle.
//      - Macro off: old value that cycle, 0xCAFE next cycle.
//   6. Parameter sweep:
//      - XLEN=64, NREG=16, NRD=3, NWR=2, ZERO_R0=0.
//      - Random writes/allocs checked against a reference model.
//      - reg0 must be writable (write 0x1 -> reads 0x1).

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Build option: REGFILE_BYPASS_EN enables the same-cycle write->read bypass.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xword_t;

  function automatic logic is_zero_reg(reg_addr_t a);
    return a == '0;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard: one busy bit per register.
// Build option: REGFILE_BYPASS_EN makes a same-cycle write clear read busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int NRD     = 2,
  parameter int NWR     = 1,
  parameter bit ZERO_R0 = 1'b1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic [NRD*AW-1:0] rs_addr,
  output logic [NRD-1:0]    rs_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;

  // alloc is applied after the clears so a new producer wins
  always_comb begin
    busy_nxt = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (alloc_en) busy_nxt[alloc_addr] = 1'b1;
    if (ZERO_R0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

  always_comb begin : rd
    logic [AW-1:0] a;
    logic          b;
    a = '0;
    b = 1'b0;
    rs_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      a = rs_addr[i*AW +: AW];
      b = busy_q[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == a)
          b = alloc_en && alloc_addr == a;
      end
`endif
      if (ZERO_R0 && a == '0) b = 1'b0;
      rs_busy[i] = b;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard.
// Build option: REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int NRD     = 2,
  parameter int NWR     = 1,
  parameter bit ZERO_R0 = 1'b1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr
);

  logic [XLEN-1:0] mem_q [NREG];

  // later ports overwrite earlier ones, so the highest index wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && !(ZERO_R0 && wr_addr[j*AW +: AW] == '0))
          mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin : rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    a = '0;
    d = '0;
    rs_data = '0;
    for (int i = 0; i < NRD; i++) begin
      a = rs_addr[i*AW +: AW];
      d = mem_q[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == a)
          d = wr_data[j*XLEN +: XLEN];
      end
`endif
      if (ZERO_R0 && a == '0) d = '0;
      rs_data[i*XLEN +: XLEN] = d;
    end
  end

  regfile_scoreboard #(
    .NREG    (NREG),
    .NRD     (NRD),
    .NWR     (NWR),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .rs_addr    (rs_addr),
    .rs_busy    (rs_busy)
  );

endmodule
